// File: rtl/stm1_tx_ohins.sv
// STM-1 TX section-overhead inserter: frame position counters, SOH/payload mux, B1/B2 insertion.
// Optional: define STM1_BIPERR_INS_EN to add b1err/b2err BIP error injection ports.
module stm1_tx_ohins #(
  parameter logic [7:0] A1_BYTE = 8'hF6,
  parameter logic [7:0] A2_BYTE = 8'h28,
  parameter logic [7:0] FILL    = 8'h00
) (
  input  logic        clk19,
  input  logic        rst19,
  input  logic        fen,
  input  logic [7:0]  pdat,
  output logic        preq,
  input  logic [7:0]  b1dat,
  input  logic        b1vld,
  input  logic [23:0] b2dat,
  input  logic        b2vld,
  input  logic [7:0]  j0_cfg,
  input  logic [7:0]  k1_cfg,
  input  logic [7:0]  k2_cfg,
  input  logic [7:0]  s1_cfg,
`ifdef STM1_BIPERR_INS_EN
  input  logic        b1err,
  input  logic        b2err,
`endif
  output logic [7:0]  pdo,
  output logic [3:0]  rrow,
  output logic [6:0]  rcol,
  output logic [1:0]  rsts,
  output logic        sof
);

  logic [3:0]  row;
  logic [6:0]  col;
  logic [1:0]  sts;
  logic [7:0]  b1_hold, j0_h, k1_h, k2_h, s1_h;
  logic [23:0] b2_hold;
  logic [7:0]  b1_ins;
  logic [23:0] b2_ins;
  logic [3:0]  soh_idx;
  logic [7:0]  soh_byte;
  logic [7:0]  nxt_byte;
  logic        active;
  logic        at_sof;
  logic        is_pld;

  assign active = rst19 & fen;
  assign at_sof = (row == 4'd0) && (col == 7'd0) && (sts == 2'd0);
  assign is_pld = (col >= 7'd3);
  assign preq   = active & is_pld;

`ifdef STM1_BIPERR_INS_EN
  assign b1_ins = b1_hold ^ {7'd0, b1err};
  assign b2_ins = b2_hold ^ {3{7'd0, b2err}};
`else
  assign b1_ins = b1_hold;
  assign b2_ins = b2_hold;
`endif

  // SOH byte for the current position; only meaningful while col < 3.
  always_comb begin
    soh_idx  = 4'(col[1:0]) * 4'd3 + 4'(sts);
    soh_byte = FILL;
    case (row)
      4'd0: case (soh_idx)
        4'd0, 4'd1, 4'd2: soh_byte = A1_BYTE;
        4'd3, 4'd4, 4'd5: soh_byte = A2_BYTE;
        4'd6:             soh_byte = j0_h;
        default:          soh_byte = FILL;
      endcase
      4'd1: if (soh_idx == 4'd0) soh_byte = b1_ins;
      // AU-4 pointer fixed at 522, NDF off
      4'd3: case (soh_idx)
        4'd0:       soh_byte = 8'h6A;
        4'd1, 4'd2: soh_byte = 8'h9B;
        4'd3:       soh_byte = 8'h0A;
        4'd4, 4'd5: soh_byte = 8'hFF;
        default:    soh_byte = FILL;
      endcase
      4'd4: case (soh_idx)
        4'd0:    soh_byte = b2_ins[23:16];
        4'd1:    soh_byte = b2_ins[15:8];
        4'd2:    soh_byte = b2_ins[7:0];
        4'd3:    soh_byte = k1_h;
        4'd6:    soh_byte = k2_h;
        default: soh_byte = FILL;
      endcase
      4'd8: if (soh_idx == 4'd0) soh_byte = s1_h;
      default: soh_byte = FILL;
    endcase
    nxt_byte = is_pld ? pdat : soh_byte;
  end

  // Position counters and the registered output byte.
  always_ff @(posedge clk19) begin
    if (!active) begin
      row  <= '0;
      col  <= '0;
      sts  <= '0;
      pdo  <= '0;
      rrow <= '0;
      rcol <= '0;
      rsts <= '0;
      sof  <= 1'b0;
    end else begin
      pdo  <= nxt_byte;
      rrow <= row;
      rcol <= col;
      rsts <= sts;
      sof  <= at_sof;
      if (sts == 2'd2) begin
        sts <= '0;
        if (col == 7'd89) begin
          col <= '0;
          row <= (row == 4'd8) ? 4'd0 : row + 4'd1;
        end else begin
          col <= col + 7'd1;
        end
      end else begin
        sts <= sts + 2'd1;
      end
    end
  end

  // BIP holds survive fen=0; the insertion mux reads the pre-load value on a same-cycle strobe.
  always_ff @(posedge clk19) begin
    if (!rst19) begin
      b1_hold <= '0;
      b2_hold <= '0;
    end else begin
      if (b1vld) b1_hold <= b1dat;
      if (b2vld) b2_hold <= b2dat;
    end
  end

  always_ff @(posedge clk19) begin
    if (!active) begin
      j0_h <= '0;
      k1_h <= '0;
      k2_h <= '0;
      s1_h <= '0;
    end else if (at_sof) begin
      j0_h <= j0_cfg;
      k1_h <= k1_cfg;
      k2_h <= k2_cfg;
      s1_h <= s1_cfg;
    end
  end

endmodule

// File: tb/tb_stm1_tx_ohins.sv
// Self-checking bench for stm1_tx_ohins: frame-position model, row0/row3 tables, B1/B2 and reset sequences.
module tb_stm1_tx_ohins;

  logic        clk19 = 1'b0;
  logic        rst19 = 1'b0;
  logic        fen = 1'b0;
  logic [7:0]  pdat = '0;
  logic        preq;
  logic [7:0]  b1dat = '0;
  logic        b1vld = 1'b0;
  logic [23:0] b2dat = '0;
  logic        b2vld = 1'b0;
  logic [7:0]  j0_cfg = '0, k1_cfg = '0, k2_cfg = '0, s1_cfg = '0;
  logic [7:0]  pdo;
  logic [3:0]  rrow;
  logic [6:0]  rcol;
  logic [1:0]  rsts;
  logic        sof;

  stm1_tx_ohins dut (
    .clk19(clk19), .rst19(rst19), .fen(fen), .pdat(pdat), .preq(preq),
    .b1dat(b1dat), .b1vld(b1vld), .b2dat(b2dat), .b2vld(b2vld),
    .j0_cfg(j0_cfg), .k1_cfg(k1_cfg), .k2_cfg(k2_cfg), .s1_cfg(s1_cfg),
    .pdo(pdo), .rrow(rrow), .rcol(rcol), .rsts(rsts), .sof(sof)
  );

  always #5 clk19 = ~clk19;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_sof = -1;

  // reference model: byte number within frame plus held values
  int          mpos = 0;
  logic [7:0]  mb1 = '0, mj0 = '0, mk1 = '0, mk2 = '0, ms1 = '0;
  logic [23:0] mb2 = '0;
  logic [7:0]  e_pdo;
  int          e_row, e_col, e_sts;
  logic        e_sof, e_preq, last_preq;

  typedef struct {
    logic [7:0] pdo;
    logic       preq;
    int         col;
    int         sts;
  } vec_t;
  vec_t row0_tbl[9];
  logic [7:0] row3_tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] soh(input int r, input int ix);
    logic [7:0] v;
    v = 8'h00;
    if (r == 0) begin
      if (ix < 3) v = 8'hF6;
      else if (ix < 6) v = 8'h28;
      else if (ix == 6) v = mj0;
    end else if (r == 1 && ix == 0) v = mb1;
    else if (r == 3) begin
      case (ix)
        0: v = 8'h6A;
        1, 2: v = 8'h9B;
        3: v = 8'h0A;
        4, 5: v = 8'hFF;
        default: v = 8'h00;
      endcase
    end else if (r == 4) begin
      case (ix)
        0: v = mb2[23:16];
        1: v = mb2[15:8];
        2: v = mb2[7:0];
        3: v = mk1;
        6: v = mk2;
        default: v = 8'h00;
      endcase
    end else if (r == 8 && ix == 0) v = ms1;
    return v;
  endfunction

  // One byte clock: predict, check preq before the edge, check registered outputs after.
  task automatic tick();
    int r, ix;
    if (!rst19 || !fen) begin
      e_pdo = 0; e_row = 0; e_col = 0; e_sts = 0; e_sof = 0; e_preq = 0;
      mpos = 0; mj0 = 0; mk1 = 0; mk2 = 0; ms1 = 0;
      last_sof = -1;
      if (!rst19) begin mb1 = 0; mb2 = 0; end
    end else begin
      r = mpos / 270;
      ix = mpos % 270;
      if (mpos == 0) begin mj0 = j0_cfg; mk1 = k1_cfg; mk2 = k2_cfg; ms1 = s1_cfg; end
      e_preq = (ix >= 9);
      e_pdo = e_preq ? pdat : soh(r, ix);
      e_row = r; e_col = ix / 3; e_sts = ix % 3;
      e_sof = (mpos == 0);
      mpos = (mpos + 1) % 2430;
    end
    if (rst19 && b1vld) mb1 = b1dat;
    if (rst19 && b2vld) mb2 = b2dat;
    #1;
    last_preq = preq;
    chk("preq", preq, e_preq);
    @(posedge clk19);
    #1;
    cyc++;
    chk("pdo", pdo, e_pdo);
    chk("rrow", rrow, e_row);
    chk("rcol", rcol, e_col);
    chk("rsts", rsts, e_sts);
    chk("sof", sof, e_sof);
    if (sof === 1'b1) begin
      if (last_sof >= 0) chk("sof_period", cyc - last_sof, 2430);
      last_sof = cyc;
    end
  endtask

  task automatic run(input int n, input bit rnd_bip);
    for (int i = 0; i < n; i++) begin
      pdat = 8'($urandom);
      b1dat = 8'($urandom);
      b2dat = 24'($urandom);
      b1vld = rnd_bip && ($urandom_range(0, 799) == 0);
      b2vld = rnd_bip && ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 299) == 0) begin
        j0_cfg = 8'($urandom); k1_cfg = 8'($urandom);
        k2_cfg = 8'($urandom); s1_cfg = 8'($urandom);
      end
      tick();
    end
    b1vld = 0;
    b2vld = 0;
  endtask

  task automatic run_to(input int p);
    int guard;
    guard = 0;
    while (mpos != p && guard < 2500) begin
      pdat = 8'($urandom);
      tick();
      guard++;
    end
    if (mpos != p) chk("run_to_timeout", guard, 0);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) begin
      row0_tbl[i].pdo = (i < 3) ? 8'hF6 : (i < 6) ? 8'h28 : (i == 6) ? 8'h3C : 8'h00;
      row0_tbl[i].preq = 1'b0;
      row0_tbl[i].col = i / 3;
      row0_tbl[i].sts = i % 3;
    end
    row3_tbl = '{8'h6A, 8'h9B, 8'h9B, 8'h0A, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};

    #6;
    // reset and fen=0 idle state
    repeat (3) tick();
    rst19 = 1;
    repeat (2) tick();
    chk("idle_pdo", pdo, 8'h00);

    // row0 table after enabling, sof expected on the first output byte
    fen = 1;
    j0_cfg = 8'h3C;
    for (int i = 0; i < 9; i++) begin
      pdat = 8'($urandom);
      tick();
      chk("row0_pdo", pdo, row0_tbl[i].pdo);
      chk("row0_preq", last_preq, row0_tbl[i].preq);
      chk("row0_col", rcol, row0_tbl[i].col);
      chk("row0_sts", rsts, row0_tbl[i].sts);
      if (i == 0) chk("first_sof", sof, 1'b1);
    end

    // incrementing payload with one-cycle lag
    run_to(270 + 9);
    for (int i = 0; i < 16; i++) begin
      pdat = 8'(i);
      tick();
      chk("pld_inc", pdo, 8'(i));
    end

    // B1 strobe in frame N inserted in frame N+1; strobe at the insertion cycle keeps the old value
    run_to(500);
    b1dat = 8'h5A; b1vld = 1; tick(); b1vld = 0;
    run_to(270);
    b1dat = 8'h77; b1vld = 1; tick(); b1vld = 0;
    chk("b1_ins", pdo, 8'h5A);
    b2dat = 24'h123456; b2vld = 1; tick(); b2vld = 0;
    run_to(270);
    tick();
    chk("b1_next", pdo, 8'h77);
    run_to(810);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("row3_ptr", pdo, row3_tbl[i]);
    end
    run_to(1080);
    tick(); chk("b2_hi", pdo, 8'h12);
    tick(); chk("b2_mid", pdo, 8'h34);
    tick(); chk("b2_lo", pdo, 8'h56);

    // randomized traffic against the model
    run(3 * 2430, 1'b1);

    // one-cycle reset at row5
    run_to(5 * 270 + 17);
    rst19 = 0; tick();
    chk("rst_pdo", pdo, 8'h00);
    chk("rst_row", rrow, 4'd5 - 4'd5);
    chk("rst_sof", sof, 1'b0);
    rst19 = 1; tick();
    chk("restart_sof", sof, 1'b1);
    run_to(270); tick();
    chk("b1_cleared", pdo, 8'h00);
    run_to(1080);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2_cleared", pdo, 8'h00);
    end

    // fen drop mid-frame keeps B1/B2
    b1dat = 8'hC3; b1vld = 1; tick(); b1vld = 0;
    run_to(1000);
    fen = 0;
    repeat (5) tick();
    chk("fen0_pdo", pdo, 8'h00);
    fen = 1;
    run_to(270); tick();
    chk("b1_retained", pdo, 8'hC3);

    run(2 * 2430, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
